// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first.
// Signed operands are multiplied as magnitudes and the sign is applied when the product is loaded.
module seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE_ST
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier;
    logic                 sign;
    logic                 last;

    // The most-negative value maps to 2^(WIDTH-1), which is representable as WIDTH-bit unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? ((~v) + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? ((~v) + (2*WIDTH)'(1)) : v;
    endfunction

    assign acc_sum = mplier[0] ? (acc + mcand) : acc;
    assign last    = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_next = DONE_ST;
            end
            DONE_ST: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            sign   <= 1'b0;
            p      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, magnitude(a, signed_mode & a[WIDTH-1])};
                        mplier <= magnitude(b, signed_mode & b[WIDTH-1]);
                        sign   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt    <= '0;
                        acc    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    // The final partial sum goes straight into p so it is valid as DONE_ST is entered.
                    if (last) p <= apply_sign(acc_sum, sign);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult (WIDTH=4): table vectors, random operands against an integer model,
// and hand sequences for held start, mid-calculation reset and back-to-back operation.
module tb_seq_mult;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int nvec = 0;
    int nmis = 0;

    seq_mult #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .p(p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [7:0]   exp;
    } vec_t;

    function automatic logic [7:0] model(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
        int xi;
        int yi;
        xi = sm ? int'($signed(x)) : int'(x);
        yi = sm ? int'($signed(y)) : int'(y);
        return 8'(xi * yi);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one multiply from IDLE and follow it to its done pulse.
    task automatic mult_op(input string name, input logic sm, input logic [W-1:0] ai,
                           input logic [W-1:0] bi, input logic hold, input logic [7:0] exp);
        logic [7:0] prev_p;
        int         j;
        int         busy_cycles;
        logic       seen;
        logic       p_stable;
        @(negedge clk);
        prev_p      = p;
        rst         = 1'b0;
        start       = 1'b1;
        signed_mode = sm;
        a           = ai;
        b           = bi;
        @(posedge clk);
        j           = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        p_stable    = 1'b1;
        while (j < 20 && !seen) begin
            @(negedge clk);
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end else begin
                if (busy) busy_cycles++;
                if (p !== prev_p) p_stable = 1'b0;
                j++;
                if (hold) begin
                    a           = W'($urandom);
                    b           = W'($urandom);
                    signed_mode = 1'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end
        check({name, " latency"}, 32'(j), 32'(W));
        check({name, " busy_cycles"}, 32'(busy_cycles), 32'(W));
        check({name, " p_held_before_done"}, 32'(p_stable), 32'd1);
        check({name, " p"}, 32'(p), 32'(exp));
        @(negedge clk);
        check({name, " done_one_cycle"}, {30'd0, busy, done}, 32'd0);
    endtask

    vec_t       tbl[9];
    logic       bb_sm[18];
    logic [W-1:0] bb_a[18];
    logic [W-1:0] bb_b[18];

    initial begin
        tbl[0] = '{1'b0, 4'd2,  4'd2,  8'h04};
        tbl[1] = '{1'b0, 4'd7,  4'd2,  8'h0E};
        tbl[2] = '{1'b0, 4'd5,  4'd2,  8'h0A};
        tbl[3] = '{1'b0, 4'd3,  4'd3,  8'h09};
        tbl[4] = '{1'b0, 4'd15, 4'd15, 8'hE1};
        tbl[5] = '{1'b0, 4'd0,  4'd9,  8'h00};
        tbl[6] = '{1'b1, 4'h8,  4'h8,  8'h40};
        tbl[7] = '{1'b1, 4'hD,  4'd5,  8'hF1};
        tbl[8] = '{1'b0, 4'hD,  4'd5,  8'h41};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {22'd0, busy, done, p}, 32'd0);

        // rst and start together keep the block idle; the next rst=0 edge accepts.
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd3;
        @(posedge clk);
        @(negedge clk);
        check("rst_with_start_idle", {30'd0, busy, done}, 32'd0);
        mult_op("first_after_reset", 1'b0, 4'd3, 4'd3, 1'b0, 8'h09);

        for (int i = 0; i < 9; i++) begin
            mult_op($sformatf("tbl%0d", i), tbl[i].sm, tbl[i].a, tbl[i].b, 1'b0, tbl[i].exp);
        end

        // p holds while idle
        repeat (3) @(negedge clk);
        check("p_hold_idle", 32'(p), 32'h41);

        // start held with operands changing during CALC
        mult_op("held_start", 1'b0, 4'd6, 4'd5, 1'b1, 8'h1E);

        for (int i = 0; i < 20; i++) begin
            logic         sm;
            logic [W-1:0] x;
            logic [W-1:0] y;
            sm = 1'($urandom);
            x  = W'($urandom);
            y  = W'($urandom);
            mult_op($sformatf("rand%0d", i), sm, x, y, 1'b0, model(sm, x, y));
        end

        // Reset in the second CALC cycle of 7x7 aborts without a done pulse.
        @(negedge clk);
        start       = 1'b1;
        signed_mode = 1'b0;
        a           = 4'd7;
        b           = 4'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", {22'd0, busy, done, p}, 32'd0);
        rst = 1'b0;
        begin
            int dcount;
            dcount = 0;
            repeat (8) begin
                @(negedge clk);
                if (done) dcount++;
            end
            check("abort_no_done", 32'(dcount), 32'd0);
        end
        mult_op("after_abort", 1'b0, 4'd3, 4'd3, 1'b0, 8'h09);

        // Back-to-back: start held, operands randomised every cycle; accepts every W+2 cycles.
        @(negedge clk);
        for (int c = 0; c < 18; c++) begin
            bb_sm[c]    = 1'($urandom);
            bb_a[c]     = W'($urandom);
            bb_b[c]     = W'($urandom);
            start       = 1'b1;
            signed_mode = bb_sm[c];
            a           = bb_a[c];
            b           = bb_b[c];
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b_done_c%0d", c), 32'(done), 32'((c % (W + 2)) == W));
            if ((c % (W + 2)) == W) begin
                check($sformatf("b2b_p_c%0d", c), 32'(p),
                      32'(model(bb_sm[c - W], bb_a[c - W], bb_b[c - W])));
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
